str_dec_avg: RTL

//  Stream decimator/averager placed directly downstream of the clock divider: consumes its cke pulse as
//  the decimation strobe. Accumulates signed ADC samples from an input stream and emits one sample per

---
 rtl/str_dec_avg.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/str_dec_avg.sv
// Stream decimator/averager: accumulates signed samples and, on each decimation strobe, emits
// either the last sample of the window or the arithmetically shifted, saturated window sum.
module str_dec_avg #(
    parameter int DW  = 14,
    parameter int DWS = 16,
    parameter int DWH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ctl_rst,
    input  logic                  cfg_avg,
    input  logic [DWH-1:0]        cfg_shr,
    input  logic                  cke,
    input  logic signed [DW-1:0]  sti_dat,
    input  logic                  sti_vld,
    output logic                  sti_rdy,
    output logic signed [DW-1:0]  sto_dat,
    output logic                  sto_vld,
    input  logic                  sto_rdy,
    output logic                  sts_ovf,
    output logic                  sts_sat
);

    localparam int DWA = DW + DWS;

    logic [DWA-1:0] acc_q, acc_d;
    logic           pnd_q, pnd_d;
    logic [DW-1:0]  sto_dat_q, sto_dat_d;
    logic           sto_vld_q, sto_vld_d;
    logic           sts_ovf_q, sts_ovf_d;
    logic           sts_sat_q, sts_sat_d;

    logic           sti_rdy_s;
    logic           accept_s;
    logic           close_s;
    logic [DWA:0]   sum_w_s;
    logic [DWA-1:0] sum_s;
    logic [DWA-1:0] shifted_s;
    logic [DW-1:0]  result_s;

    // The one-bit-wider sum overflowed when its two top bits disagree.
    function automatic logic acc_ovf(input logic [DWA:0] s);
        return s[DWA] != s[DWA-1];
    endfunction

    function automatic logic [DWA-1:0] acc_clamp(input logic [DWA:0] s);
        if (s[DWA] != s[DWA-1]) begin
            if (s[DWA]) begin
                return {1'b1, {(DWA-1){1'b0}}};
            end else begin
                return {1'b0, {(DWA-1){1'b1}}};
            end
        end else begin
            return s[DWA-1:0];
        end
    endfunction

    // Fits in DW bits only if every bit above the DW-bit sign bit repeats it.
    function automatic logic dw_ovf(input logic [DWA-1:0] v);
        return ~((&v[DWA-1:DW-1]) | ~(|v[DWA-1:DW-1]));
    endfunction

    function automatic logic [DW-1:0] dw_clamp(input logic [DWA-1:0] v);
        if (dw_ovf(v)) begin
            if (v[DWA-1]) begin
                return {1'b1, {(DW-1){1'b0}}};
            end else begin
                return {1'b0, {(DW-1){1'b1}}};
            end
        end else begin
            return v[DW-1:0];
        end
    endfunction

    // Handshake, window-close detection and the saturated sum/result datapath.
    always_comb begin
        sti_rdy_s = ~sto_vld_q | sto_rdy;
        accept_s  = sti_vld & sti_rdy_s;
        close_s   = accept_s & (pnd_q | cke);
        sum_w_s   = {acc_q[DWA-1], acc_q} + {{(DWS+1){sti_dat[DW-1]}}, sti_dat};
        sum_s     = acc_clamp(sum_w_s);
        shifted_s = $signed(sum_s) >>> cfg_shr;
        if (cfg_avg) begin
            result_s = dw_clamp(shifted_s);
        end else begin
            result_s = sti_dat;
        end
    end

    // Next-state for accumulator, pending flag, output register and sticky status.
    always_comb begin
        acc_d     = acc_q;
        pnd_d     = pnd_q;
        sto_dat_d = sto_dat_q;
        sto_vld_d = sto_vld_q;
        sts_ovf_d = sts_ovf_q;
        sts_sat_d = sts_sat_q;
        if (ctl_rst) begin
            acc_d     = '0;
            pnd_d     = 1'b0;
            sto_dat_d = '0;
            sto_vld_d = 1'b0;
            sts_ovf_d = 1'b0;
            sts_sat_d = 1'b0;
        end else begin
            if (close_s) begin
                acc_d     = '0;
                pnd_d     = 1'b0;
                sto_dat_d = result_s;
                sto_vld_d = 1'b1;
            end else begin
                if (accept_s) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                if (cke) begin
                    pnd_d = 1'b1;
                end else begin
                    pnd_d = pnd_q;
                end
                if (sto_rdy) begin
                    sto_vld_d = 1'b0;
                end else begin
                    sto_vld_d = sto_vld_q;
                end
            end
            // A strobe arriving while a close is still pending is merged, not queued.
            if (cke & pnd_q & ~accept_s) begin
                sts_ovf_d = 1'b1;
            end else begin
                sts_ovf_d = sts_ovf_q;
            end
            if ((accept_s & acc_ovf(sum_w_s)) | (close_s & cfg_avg & dw_ovf(shifted_s))) begin
                sts_sat_d = 1'b1;
            end else begin
                sts_sat_d = sts_sat_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q     <= '0;
            pnd_q     <= 1'b0;
            sto_dat_q <= '0;
            sto_vld_q <= 1'b0;
            sts_ovf_q <= 1'b0;
            sts_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pnd_q     <= pnd_d;
            sto_dat_q <= sto_dat_d;
            sto_vld_q <= sto_vld_d;
            sts_ovf_q <= sts_ovf_d;
            sts_sat_q <= sts_sat_d;
        end
    end

    assign sti_rdy = sti_rdy_s;
    assign sto_dat = sto_dat_q;
    assign sto_vld = sto_vld_q;
    assign sts_ovf = sts_ovf_q;
    assign sts_sat = sts_sat_q;

endmodule
